// File: rtl/r_universal_param.sv
// Universal WIDTH-bit register: load, shift/rotate bursts, up/down count; SYNC_CLR_EN adds a synchronous clear port clr.
// Latency: single-step ops update q on the accepting edge and pulse done the cycle after; an N-step burst takes N edges.
// Backpressure: requests are sampled only while busy is low; en/mode/cnt/d are ignored during a burst.
module r_universal_param #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             reset,
`ifdef SYNC_CLR_EN
    input  logic             clr,
`endif
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [CNTW-1:0]  cnt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             zero
);

    localparam logic [2:0] M_HOLD = 3'd0;
    localparam logic [2:0] M_LOAD = 3'd1;
    localparam logic [2:0] M_SHL  = 3'd2;
    localparam logic [2:0] M_SHR  = 3'd3;
    localparam logic [2:0] M_ROL  = 3'd4;
    localparam logic [2:0] M_ROR  = 3'd5;
    localparam logic [2:0] M_INC  = 3'd6;
    localparam logic [2:0] M_DEC  = 3'd7;

    localparam logic [WIDTH-1:0] Q_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0]  CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state;
    logic [2:0]      run_mode;
    logic [CNTW-1:0] remaining;

    // One shift/rotate step; result is {bit shifted out, new contents}.
    function automatic logic [WIDTH:0] step_fn(input logic [2:0] m, input logic [WIDTH-1:0] v,
                                               input logic sl, input logic sr);
        case (m)
            M_SHL:   step_fn = {v[WIDTH-1], v[WIDTH-2:0], sl};
            M_SHR:   step_fn = {v[0], sr, v[WIDTH-1:1]};
            M_ROL:   step_fn = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            default: step_fn = {v[0], v[0], v[WIDTH-1:1]};
        endcase
    endfunction

    assign zero = (q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            run_mode  <= M_HOLD;
            remaining <= '0;
            q         <= '0;
            sout      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            carry     <= 1'b0;
`ifdef SYNC_CLR_EN
        end else if (clr) begin
            state     <= IDLE;
            remaining <= '0;
            q         <= '0;
            sout      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            carry     <= 1'b0;
`endif
        end else begin
            done  <= 1'b0;
            carry <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        case (mode)
                            M_HOLD: ;
                            M_LOAD: begin
                                q    <= d;
                                done <= 1'b1;
                            end
                            M_INC: begin
                                q     <= q + Q_ONE;
                                carry <= &q;
                                done  <= 1'b1;
                            end
                            M_DEC: begin
                                q     <= q - Q_ONE;
                                carry <= ~|q;
                                done  <= 1'b1;
                            end
                            default: begin
                                {sout, q} <= step_fn(mode, q, sin_l, sin_r);
                                // cnt of 0 or 1 is a single step with no RUN phase
                                if (cnt > CNT_ONE) begin
                                    state     <= RUN;
                                    run_mode  <= mode;
                                    remaining <= cnt - CNT_ONE;
                                    busy      <= 1'b1;
                                end else begin
                                    done <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                RUN: begin
                    {sout, q} <= step_fn(run_mode, q, sin_l, sin_r);
                    remaining <= remaining - CNT_ONE;
                    if (remaining == CNT_ONE) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_r_universal_param.sv
// Directed + random bench for r_universal_param (WIDTH=8, CNTW=3) against an arithmetic reference model.
module tb_r_universal_param;
    localparam int WIDTH = 8;
    localparam int CNTW  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [2:0]       mode;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic             sout, busy, done, carry, zero;
`ifdef SYNC_CLR_EN
    logic             clr;
`endif

    int errors = 0;
    int checks = 0;
    // reference model: register value as an integer 0..255
    int mq;
    int msout;
    int mcarry;

    r_universal_param #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk(clk),
        .reset(reset),
`ifdef SYNC_CLR_EN
        .clr(clr),
`endif
        .en(en),
        .mode(mode),
        .cnt(cnt),
        .d(d),
        .sin_l(sin_l),
        .sin_r(sin_r),
        .q(q),
        .sout(sout),
        .busy(busy),
        .done(done),
        .carry(carry),
        .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int exp_busy, input int exp_done);
        check({tag, ".q"},     32'(q),     32'(mq));
        check({tag, ".sout"},  32'(sout),  32'(msout));
        check({tag, ".busy"},  32'(busy),  32'(exp_busy));
        check({tag, ".done"},  32'(done),  32'(exp_done));
        check({tag, ".carry"}, 32'(carry), 32'(mcarry));
        check({tag, ".zero"},  32'(zero),  32'(mq == 0));
    endtask

    // Effect of one operation step, using the serial inputs currently driven.
    task automatic model_step(input int m, input int dv);
        int old;
        old    = mq;
        mcarry = 0;
        case (m)
            1: mq = dv;
            2: begin msout = old / 128; mq = (old * 2) % 256 + int'(sin_l); end
            3: begin msout = old % 2;   mq = old / 2 + int'(sin_r) * 128; end
            4: begin msout = old / 128; mq = (old * 2) % 256 + old / 128; end
            5: begin msout = old % 2;   mq = old / 2 + (old % 2) * 128; end
            6: begin mcarry = (old == 255); mq = (old + 1) % 256; end
            7: begin mcarry = (old == 0);   mq = (old + 255) % 256; end
            default: ;
        endcase
    endtask

    // Issue one request, check every edge of it, then one idle cycle afterwards.
    // abort_after>0 returns after that many edges with the burst still in flight.
    task automatic run_op(input string tag, input int m, input int c, input int dv,
                          input int sl, input int sr, input bit rsin, input int abort_after);
        int n;
        n = (m >= 2 && m <= 5) ? ((c == 0) ? 1 : c) : 1;
        en = 1'b1; mode = 3'(m); cnt = CNTW'(c); d = 8'(dv);
        sin_l = 1'(sl); sin_r = 1'(sr);
        for (int s = 0; s < n; s++) begin
            model_step((s == 0) ? m : m, dv);
            tick();
            check_all(tag, int'(s < n - 1), int'(m != 0 && s == n - 1));
            if (abort_after == s + 1) begin
                en = 1'b0;
                return;
            end
            if (s < n - 1) begin
                // garbage requests while busy must be ignored
                en = 1'b1; mode = 3'($urandom_range(0, 7)); d = 8'($urandom);
                cnt = CNTW'($urandom_range(0, 7));
                if (rsin) begin
                    sin_l = 1'($urandom_range(0, 1));
                    sin_r = 1'($urandom_range(0, 1));
                end
            end else begin
                en = 1'b0;
            end
        end
        mcarry = 0;
        tick();
        check_all({tag, ".after"}, 0, 0);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 3'd0; cnt = '0; d = '0; sin_l = 1'b0; sin_r = 1'b0;
`ifdef SYNC_CLR_EN
        clr = 1'b0;
`endif
        mq = 0; msout = 0; mcarry = 0;
        #1;
        check_all("reset", 0, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op("load_a5", 1, 0, 'hA5, 0, 0, 0, 0);
        run_op("shl3", 2, 3, 0, 1, 0, 0, 0);
        check("shl3_literal_q", 32'(q), 32'h2F);

        run_op("load_81", 1, 0, 'h81, 0, 0, 0, 0);
        run_op("ror0", 5, 0, 0, 0, 0, 0, 0);
        check("ror0_literal_q", 32'(q), 32'hC0);

        run_op("load_ff", 1, 0, 'hFF, 0, 0, 0, 0);
        run_op("inc_wrap", 6, 0, 0, 0, 0, 0, 0);
        check("inc_wrap_literal_q", 32'(q), 32'h00);
        run_op("dec_wrap", 7, 0, 0, 0, 0, 0, 0);
        check("dec_wrap_literal_q", 32'(q), 32'hFF);

        run_op("load_01", 1, 0, 'h01, 0, 0, 0, 0);
        run_op("shr7", 3, 7, 0, 0, 0, 0, 0);
        check("shr7_literal_zero", 32'(zero), 32'd1);

        // asynchronous reset between edges in the middle of a burst
        run_op("load_5a", 1, 0, 'h5A, 0, 0, 0, 0);
        run_op("shl5_abort", 2, 5, 0, 1, 0, 0, 2);
        #2 reset = 1'b1;
        #1;
        mq = 0; msout = 0; mcarry = 0;
        check_all("async_reset", 0, 0);
        #2 reset = 1'b0;
        run_op("post_reset_rol2", 4, 2, 0, 0, 0, 0, 0);
        run_op("post_reset_load", 1, 0, 'h96, 0, 0, 0, 0);

`ifdef SYNC_CLR_EN
        run_op("load_3c", 1, 0, 'h3C, 0, 0, 0, 0);
        run_op("shl5_clr", 2, 5, 0, 0, 0, 0, 2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        mq = 0; msout = 0; mcarry = 0;
        check_all("clr", 0, 0);
        tick();
        check_all("clr.after", 0, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                en = 1'b0; mode = 3'($urandom_range(1, 7)); d = 8'($urandom);
                mcarry = 0;
                tick();
                check_all("rand_idle", 0, 0);
            end else begin
                run_op("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 1)), 1'b1, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
